// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with parametrised width and depth.
// Registered read data with a one-cycle valid strobe, run-time programmable
// almost_full/almost_empty thresholds, occupancy count and one-cycle error
// pulses for rejected requests. A write is accepted at full if a read is
// accepted in the same cycle. A read at empty is always rejected; there is
// no write-to-read bypass.
// Optional feature: define FIFO_WATERMARK_EN to add Fifo_peak, the highest
// occupancy seen since reset.
module fifo_param #(
  parameter int unsigned BITNUMBER = 8,
  parameter int unsigned LENGTH    = 8,
  parameter int unsigned PTRWIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Fifo_wr,
  input  logic                 Fifo_rd,
  input  logic [BITNUMBER-1:0] Fifo_Data_in,
  input  logic [PTRWIDTH:0]    umbral_alto,
  input  logic [PTRWIDTH:0]    umbral_bajo,
  output logic [BITNUMBER-1:0] Fifo_Data_out,
  output logic                 Fifo_valid,
  output logic                 Fifo_full,
  output logic                 Fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 Fifo_wr_error,
  output logic                 Fifo_rd_error,
`ifdef FIFO_WATERMARK_EN
  output logic [PTRWIDTH:0]    Fifo_peak,
`endif
  output logic [PTRWIDTH:0]    Fifo_count
);

  localparam int unsigned CntW = PTRWIDTH + 1;

  // Storage; deliberately not cleared by reset.
  logic [BITNUMBER-1:0] mem_q [LENGTH];

  logic [PTRWIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRWIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [BITNUMBER-1:0] data_out_q, data_out_d;
  logic                 valid_q;
  logic                 wr_err_q;
  logic                 rd_err_q;

  logic                 full;
  logic                 empty;
  logic                 rd_ok;
  logic                 wr_ok;

  // Status decode from the registered count and the accept rules.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CntW'(LENGTH));
    rd_ok = Fifo_rd & ~empty;
    // At full, a same-cycle read frees the slot the write lands in.
    wr_ok = Fifo_wr & (~full | rd_ok);
  end

  // Next-state for pointers, occupancy and read data.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    // Pointers wrap naturally because LENGTH == 2**PTRWIDTH.
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTRWIDTH'(1);
    end
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PTRWIDTH'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Memory write port; requests seen during reset are dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      mem_q[wr_ptr_q] <= Fifo_Data_in;
    end
  end

  // Control state, read data and one-cycle strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= rd_ok;
      wr_err_q   <= Fifo_wr & ~wr_ok;
      rd_err_q   <= Fifo_rd & empty;
    end
  end

`ifdef FIFO_WATERMARK_EN
  logic [CntW-1:0] peak_q, peak_d;

  // Track the highest occupancy; compared against the count being loaded.
  always_comb begin
    peak_d = (count_d > peak_q) ? count_d : peak_q;
  end

  // Peak register, cleared with the rest of the FIFO state.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign Fifo_peak = peak_q;
`endif

  // Outputs; threshold flags follow the threshold inputs combinationally.
  assign Fifo_Data_out = data_out_q;
  assign Fifo_valid    = valid_q;
  assign Fifo_wr_error = wr_err_q;
  assign Fifo_rd_error = rd_err_q;
  assign Fifo_count    = count_q;
  assign Fifo_full     = full;
  assign Fifo_empty    = empty;
  // Unsigned compares: umbral_alto == 0 and umbral_bajo >= LENGTH saturate to 1.
  assign almost_full   = (count_q >= umbral_alto);
  assign almost_empty  = (count_q <= umbral_bajo);

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: the stimulus pushes the word each accepted
// read must return; a negedge monitor pops and compares on Fifo_valid.
// Status outputs are compared against hand-computed constants after each edge.
module tb_fifo_param;

  logic       clk;
  logic       reset;
  logic       Fifo_wr;
  logic       Fifo_rd;
  logic [7:0] Fifo_Data_in;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic [7:0] Fifo_Data_out;
  logic       Fifo_valid;
  logic       Fifo_full;
  logic       Fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic       Fifo_wr_error;
  logic       Fifo_rd_error;
  logic [3:0] Fifo_count;
`ifdef FIFO_WATERMARK_EN
  logic [3:0] Fifo_peak;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  fifo_param #(
    .BITNUMBER(8),
    .LENGTH   (8),
    .PTRWIDTH (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Fifo_wr      (Fifo_wr),
    .Fifo_rd      (Fifo_rd),
    .Fifo_Data_in (Fifo_Data_in),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .Fifo_Data_out(Fifo_Data_out),
    .Fifo_valid   (Fifo_valid),
    .Fifo_full    (Fifo_full),
    .Fifo_empty   (Fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .Fifo_wr_error(Fifo_wr_error),
    .Fifo_rd_error(Fifo_rd_error),
`ifdef FIFO_WATERMARK_EN
    .Fifo_peak    (Fifo_peak),
`endif
    .Fifo_count   (Fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic wr, input logic rd, input logic [7:0] din);
    reset        = rst;
    Fifo_wr      = wr;
    Fifo_rd      = rd;
    Fifo_Data_in = din;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid read data word must match the oldest expected word.
  always @(negedge clk) begin
    if (Fifo_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_data: got unexpected valid word %0h, required no valid", Fifo_Data_out);
      end else begin
        exp_word = exp_q.pop_front();
        if (Fifo_Data_out !== exp_word) begin
          n_errors++;
          $display("FAIL rd_data: got %0h, required %0h", Fifo_Data_out, exp_word);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    Fifo_wr      = 1'b0;
    Fifo_rd      = 1'b0;
    Fifo_Data_in = 8'h00;
    umbral_alto  = 4'd6;
    umbral_bajo  = 4'd2;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_count", Fifo_count, 0);
    check("rst_empty", Fifo_empty, 1);
    check("rst_full", Fifo_full, 0);
    check("rst_valid", Fifo_valid, 0);
    check("rst_dout", Fifo_Data_out, 0);
    check("rst_wr_err", Fifo_wr_error, 0);
    check("rst_rd_err", Fifo_rd_error, 0);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_almost_full", almost_full, 0);

    // Fill with 0x11..0x18.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h11 + 8'(i));
      check("fill_count", Fifo_count, i + 1);
      check("fill_almost_full", almost_full, (i + 1 >= 6) ? 1 : 0);
      check("fill_wr_err", Fifo_wr_error, 0);
    end
    check("fill_full", Fifo_full, 1);
    check("fill_empty", Fifo_empty, 0);
    check("fill_almost_empty", almost_empty, 0);

    // Write at full is rejected.
    step(1'b0, 1'b1, 1'b0, 8'hAA);
    check("ovf_wr_err", Fifo_wr_error, 1);
    check("ovf_count", Fifo_count, 8);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("ovf_wr_err_clear", Fifo_wr_error, 0);
    check("ovf_count_hold", Fifo_count, 8);

    // Read+write at full: both accepted.
    exp_q.push_back(8'h11);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    check("rw_full_valid", Fifo_valid, 1);
    check("rw_full_dout", Fifo_Data_out, 8'h11);
    check("rw_full_count", Fifo_count, 8);
    check("rw_full_full", Fifo_full, 1);
    check("rw_full_wr_err", Fifo_wr_error, 0);
    check("rw_full_rd_err", Fifo_rd_error, 0);

    // Drain: 0x12..0x18 then 0x55 across the pointer wrap.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back((i < 7) ? 8'h12 + 8'(i) : 8'h55);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check("drain_valid", Fifo_valid, 1);
      check("drain_count", Fifo_count, 7 - i);
    end
    check("drain_empty", Fifo_empty, 1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("idle_valid", Fifo_valid, 0);
    check("idle_dout_hold", Fifo_Data_out, 8'h55);

    // Read+write at empty: read rejected, write accepted.
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    check("rw_empty_rd_err", Fifo_rd_error, 1);
    check("rw_empty_wr_err", Fifo_wr_error, 0);
    check("rw_empty_valid", Fifo_valid, 0);
    check("rw_empty_dout", Fifo_Data_out, 8'h55);
    check("rw_empty_count", Fifo_count, 1);
    exp_q.push_back(8'h3C);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("rd_3c_rd_err_clear", Fifo_rd_error, 0);
    check("rd_3c_valid", Fifo_valid, 1);
    check("rd_3c_count", Fifo_count, 0);

    // Reset mid-operation with a write pending.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h01 + 8'(i));
    end
    check("pre_rst_count", Fifo_count, 5);
    step(1'b1, 1'b1, 1'b0, 8'h99);
    check("mid_rst_count", Fifo_count, 0);
    check("mid_rst_empty", Fifo_empty, 1);
    check("mid_rst_dout", Fifo_Data_out, 0);
    check("mid_rst_wr_err", Fifo_wr_error, 0);
    check("mid_rst_rd_err", Fifo_rd_error, 0);
    step(1'b0, 1'b1, 1'b0, 8'h7E);
    check("post_rst_count", Fifo_count, 1);

    // Threshold boundaries at count 1; flags follow inputs without a clock.
    umbral_bajo = 4'd0;  #1; check("thr_bajo0", almost_empty, 0);
    umbral_bajo = 4'd1;  #1; check("thr_bajo1", almost_empty, 1);
    umbral_bajo = 4'd8;  #1; check("thr_bajo8", almost_empty, 1);
    umbral_bajo = 4'd15; #1; check("thr_bajo15", almost_empty, 1);
    umbral_alto = 4'd2;  #1; check("thr_alto2", almost_full, 0);
    umbral_alto = 4'd1;  #1; check("thr_alto1", almost_full, 1);
    umbral_alto = 4'd0;  #1; check("thr_alto0", almost_full, 1);
    umbral_alto = 4'd6;
    umbral_bajo = 4'd2;

    exp_q.push_back(8'h7E);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check("rd_7e_valid", Fifo_valid, 1);
    check("rd_7e_count", Fifo_count, 0);

`ifdef FIFO_WATERMARK_EN
    // Watermark: write 5, read 3, write 1 -> peak 5; reset clears it.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("peak_rst", Fifo_peak, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h21 + 8'(i));
      check("peak_fill", Fifo_peak, i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h21 + 8'(i));
      step(1'b0, 1'b0, 1'b1, 8'h00);
    end
    step(1'b0, 1'b1, 1'b0, 8'h26);
    check("peak_count", Fifo_count, 3);
    check("peak_hold", Fifo_peak, 5);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("peak_clear", Fifo_peak, 0);
`endif

    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("pending_reads", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
